// File: rtl/mdio_responder_if.sv
// mdio_responder_if: MDIO pad pins plus the write-commit and busy signals of the PHY-side responder
interface mdio_responder_if;
  logic mdio_mdc;
  logic mdio_mdd_i;
  logic mdio_mdd_o;
  logic mdio_mdd_oe;
  logic wr_valid;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  logic busy;
  modport master (
    output mdio_mdc, mdio_mdd_i,
    input mdio_mdd_o, mdio_mdd_oe, wr_valid, wr_addr, wr_data, busy
  );
  modport slave (
    input mdio_mdc, mdio_mdd_i,
    output mdio_mdd_o, mdio_mdd_oe, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY responder with 32x16 register file; define MDIO_RESP_PRE_SUPPRESS_EN for preamble suppression
module mdio_responder #(
  parameter logic [4:0] PHYAD = 5'd1,
  parameter logic [15:0] PHY_ID1 = 16'h0141,
  parameter logic [15:0] PHY_ID2 = 16'h0CC2
) (
  input logic sys0_clk,
  input logic sys0_rst,
  mdio_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ST2, OP, PHYA, REGA, TA, DATA, SKIP} state_t;
  state_t state, state_nxt;
  logic [1:0] mdc_s, mdd_s;
  logic mdc_d, tick, b, start_ok, rd, rd_nxt, o_nxt, oe_nxt, commit;
  logic [5:0] pre_cnt, pre_cnt_nxt;
  logic [4:0] cnt, cnt_nxt, ra, ra_nxt;
  logic [14:0] sh, sh_nxt;
  logic [15:0] rd_word, wd;
  logic [15:0] regs [32];

  function automatic logic [15:0] rst_val(input int i);
    return i == 0 ? 16'h1140 : i == 1 ? 16'h796D : i == 2 ? PHY_ID1 : i == 3 ? PHY_ID2 : 16'h0;
  endfunction

  assign tick = mdc_s[1] & ~mdc_d;
  assign b = mdd_s[1];
  assign rd_word = ra == 5'd0 ? {1'b0, regs[0][14:0]} : regs[ra];
  assign wd = {sh, b};

`ifdef MDIO_RESP_PRE_SUPPRESS_EN
  logic armed;
  always_ff @(posedge sys0_clk or posedge sys0_rst)
    if (sys0_rst) armed <= 1'b1;
    else if (state != IDLE) armed <= 1'b0;
    else if (tick) armed <= 1'b1;
  assign start_ok = armed;
`else
  assign start_ok = pre_cnt == 6'd32;
`endif

  always_ff @(posedge sys0_clk or posedge sys0_rst)
    if (sys0_rst) begin
      mdc_s <= '0;
      mdd_s <= '0;
      mdc_d <= 1'b0;
    end else begin
      mdc_s <= {mdc_s[0], bus.mdio_mdc};
      mdd_s <= {mdd_s[0], bus.mdio_mdd_i};
      mdc_d <= mdc_s[1];
    end

  always_ff @(posedge sys0_clk or posedge sys0_rst)
    if (sys0_rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (tick)
      case (state)
        IDLE: state_nxt = !b && start_ok ? ST2 : IDLE;
        ST2: state_nxt = b ? OP : IDLE;
        OP: state_nxt = !cnt[0] ? OP : (sh[0] ^ b) ? PHYA : IDLE;
        PHYA: state_nxt = cnt == 5'd4 ? REGA : PHYA;
        REGA: state_nxt = cnt != 5'd4 ? REGA : sh[8:4] == PHYAD ? TA : SKIP;
        TA: state_nxt = cnt[0] ? DATA : TA;
        DATA: state_nxt = cnt == 5'd15 ? IDLE : DATA;
        SKIP: state_nxt = cnt == 5'd17 ? IDLE : SKIP;
      endcase
  end

  always_comb begin
    pre_cnt_nxt = state != IDLE ? 6'd0 : !tick ? pre_cnt : !b ? 6'd0 : pre_cnt == 6'd32 ? pre_cnt : pre_cnt + 6'd1;
    cnt_nxt = state_nxt != state ? 5'd0 : tick ? cnt + 5'd1 : cnt;
    sh_nxt = !tick ? sh : (state == TA && cnt[0]) ? rd_word[14:0] : (state inside {OP, PHYA, REGA, DATA}) ? {sh[13:0], b} : sh;
    ra_nxt = (tick && state == REGA && cnt == 5'd4) ? {sh[3:0], b} : ra;
    rd_nxt = (tick && state == OP && cnt[0]) ? sh[0] : rd;
    o_nxt = !tick ? bus.mdio_mdd_o : state == TA ? (cnt[0] & rd_word[15]) : state == DATA ? ((cnt != 5'd15) & sh[14]) : bus.mdio_mdd_o;
    oe_nxt = !tick ? bus.mdio_mdd_oe : (state == TA && !cnt[0] && rd) ? 1'b1 : (state == DATA && cnt == 5'd15) ? 1'b0 : bus.mdio_mdd_oe;
    commit = tick && state == DATA && cnt == 5'd15 && !rd;
  end

  always_ff @(posedge sys0_clk or posedge sys0_rst)
    if (sys0_rst) begin
      pre_cnt <= '0;
      cnt <= '0;
      sh <= '0;
      ra <= '0;
      rd <= 1'b0;
      bus.mdio_mdd_o <= 1'b0;
      bus.mdio_mdd_oe <= 1'b0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= rst_val(i);
    end else begin
      pre_cnt <= pre_cnt_nxt;
      cnt <= cnt_nxt;
      sh <= sh_nxt;
      ra <= ra_nxt;
      rd <= rd_nxt;
      bus.mdio_mdd_o <= o_nxt;
      bus.mdio_mdd_oe <= oe_nxt;
      bus.wr_valid <= commit;
      bus.busy <= state_nxt != IDLE;
      if (commit) begin
        bus.wr_addr <= ra;
        bus.wr_data <= wd;
        if (ra == 5'd0 && wd[15])
          for (int i = 0; i < 32; i++) regs[i] <= rst_val(i);
        else if (ra != 5'd2 && ra != 5'd3)
          regs[ra] <= wd;
      end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO frames against mdio_responder with hand-computed expectations
module tb_mdio_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host = 1'b1;
  int checks = 0;
  int failures = 0;
  int wv_cnt = 0;
  int oe_cnt = 0;

  mdio_responder_if bus();
  mdio_responder dut (.sys0_clk(clk), .sys0_rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.mdio_mdd_i = bus.mdio_mdd_oe ? bus.mdio_mdd_o : host;

  always @(negedge clk) begin
    wv_cnt += int'(bus.wr_valid);
    oe_cnt += int'(bus.mdio_mdd_oe);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v, output logic line, output logic oe);
    host = v;
    bus.mdio_mdc = 1'b0;
    repeat (6) @(negedge clk);
    line = bus.mdio_mdd_i;
    oe = bus.mdio_mdd_oe;
    bus.mdio_mdc = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_ones(input int n);
    logic l, e;
    for (int i = 0; i < n; i++) send_bit(1'b1, l, e);
  endtask

  task automatic send_hdr(input logic rd_op, input logic [4:0] pa, input logic [4:0] ra);
    logic [13:0] hdr;
    logic l, e;
    hdr = {2'b01, rd_op ? 2'b10 : 2'b01, pa, ra};
    for (int i = 13; i >= 0; i--) send_bit(hdr[i], l, e);
  endtask

  task automatic frame(input int npre, input logic rd_op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] d, output logic [17:0] ln, output logic [17:0] oes);
    logic [17:0] w;
    logic l, e;
    w = rd_op ? 18'h3FFFF : {2'b10, d};
    send_ones(npre);
    send_hdr(rd_op, pa, ra);
    for (int i = 0; i < 18; i++) begin
      send_bit(w[17-i], l, e);
      ln[17-i] = l;
      oes[17-i] = e;
    end
  endtask

  task automatic read_check(input string tag, input logic [4:0] ra, input logic [15:0] exp);
    logic [17:0] ln, oes;
    frame(32, 1'b1, 5'd1, ra, 16'h0, ln, oes);
    check(tag, {16'h0, ln[15:0]}, {16'h0, exp});
  endtask

  initial begin
    logic [17:0] ln, oes;
    logic l, e;
    int w0, o0;
    bus.mdio_mdc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", bus.mdio_mdd_oe, 0);
    check("rst_o", bus.mdio_mdd_o, 0);
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    w0 = wv_cnt;
    frame(32, 1'b0, 5'd1, 5'd4, 16'hA5C3, ln, oes);
    check("wr4_pulses", wv_cnt - w0, 1);
    check("wr4_addr", bus.wr_addr, 4);
    check("wr4_data", bus.wr_data, 16'hA5C3);
    check("wr4_busy_after", bus.busy, 0);
    read_check("rd4", 5'd4, 16'hA5C3);

    frame(32, 1'b1, 5'd1, 5'd2, 16'h0, ln, oes);
    check("rd2_data", ln[15:0], 16'h0141);
    check("rd2_ta1_oe", oes[17], 0);
    check("rd2_ta2_drive", {oes[16], ln[16]}, 2'b10);
    check("rd2_data_oe", oes[15:0], 16'hFFFF);
    check("rd2_oe_after", bus.mdio_mdd_oe, 0);
    read_check("rd3", 5'd3, 16'h0CC2);
    read_check("rd0", 5'd0, 16'h1140);
    read_check("rd1", 5'd1, 16'h796D);

    w0 = wv_cnt;
    o0 = oe_cnt;
    frame(32, 1'b0, 5'd7, 5'd5, 16'hFFFF, ln, oes);
    frame(32, 1'b1, 5'd7, 5'd5, 16'h0, ln, oes);
    check("phy7_pulses", wv_cnt - w0, 0);
    check("phy7_oe_cycles", oe_cnt - o0, 0);
    read_check("rd5_after_skip", 5'd5, 16'h0000);

    w0 = wv_cnt;
    frame(31, 1'b0, 5'd1, 5'd6, 16'h1234, ln, oes);
`ifdef MDIO_RESP_PRE_SUPPRESS_EN
    check("pre31_pulses", wv_cnt - w0, 1);
    read_check("rd6_pre31", 5'd6, 16'h1234);
`else
    check("pre31_pulses", wv_cnt - w0, 0);
    read_check("rd6_pre31", 5'd6, 16'h0000);
`endif

    frame(32, 1'b0, 5'd1, 5'd2, 16'hFFFF, ln, oes);
    read_check("rd2_readonly", 5'd2, 16'h0141);

    w0 = wv_cnt;
    o0 = oe_cnt;
    send_ones(32);
    send_bit(1'b0, l, e);
    check("st2_busy", bus.busy, 1);
    send_bit(1'b0, l, e);
    check("bad_st_busy", bus.busy, 0);
    send_ones(32);
    send_bit(1'b0, l, e);
    send_bit(1'b1, l, e);
    send_bit(1'b1, l, e);
    send_bit(1'b1, l, e);
    check("op11_busy", bus.busy, 0);
    check("abort_pulses", wv_cnt - w0, 0);
    check("abort_oe_cycles", oe_cnt - o0, 0);
    read_check("rd4_after_abort", 5'd4, 16'hA5C3);

    w0 = wv_cnt;
    frame(32, 1'b0, 5'd1, 5'd0, 16'h8000, ln, oes);
    check("soft_rst_pulses", wv_cnt - w0, 1);
    check("soft_rst_addr", bus.wr_addr, 0);
    check("soft_rst_data", bus.wr_data, 16'h8000);
    read_check("rd4_after_soft_rst", 5'd4, 16'h0000);
    read_check("rd0_after_soft_rst", 5'd0, 16'h1140);

    w0 = wv_cnt;
    send_ones(32);
    send_hdr(1'b1, 5'd1, 5'd1);
    send_bit(1'b1, l, e);
    send_bit(1'b1, l, e);
    check("mid_oe_on", bus.mdio_mdd_oe, 1);
    #2 rst = 1'b1;
    #1 check("mid_oe_off", bus.mdio_mdd_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_busy_off", bus.busy, 0);
    check("mid_pulses", wv_cnt - w0, 0);
    read_check("rd1_after_rst", 5'd1, 16'h796D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side Clause-22 MDIO management responder: the far end of the design's MDIO master (`mdio_mdc` / `mdio_mdd`). It oversamples MDC in the `sys0_clk` domain, decodes read and write frames addressed to its PHY address, and serves a 32 x 16 register file. It is used as a loopback PHY model for board bring-up and as a standalone management target behind the top-level tristate.

## Interface
Parameters:
- `PHYAD`, 5'd1: PHY address this block answers to.
- `PHY_ID1`, 16'h0141: read-only value of register 2.
- `PHY_ID2`, 16'h0CC2: read-only value of register 3.

Ports:
- `sys0_clk` in 1: single clock for all logic.
- `sys0_rst` in 1: reset, asynchronous, active-high.
- `mdio_mdc` in 1: management clock, asynchronous to `sys0_clk`.
- `mdio_mdd_i` in 1: MDIO line as sampled from the pad.
- `mdio_mdd_o` out 1: MDIO drive value.
- `mdio_mdd_oe` out 1: MDIO drive enable; the pad is released when low.
- `wr_valid` out 1: one-cycle pulse on each committed write.
- `wr_addr` out 5: register address of the committed write.
- `wr_data` out 16: data of the committed write.
- `busy` out 1: high from start-of-frame detection until return to IDLE.

## Operation
- MDC and MDD each pass through a 2-flop synchronizer. A rising edge is detected on MDC (synchronized, delayed vs synchronized). All frame logic advances only on a detected rising edge ("tick"). Each tick samples one bit.
- Register file reset values:
  - reg0 = 16'h1140.
  - reg1 = 16'h796D.
  - reg2/reg3 = `PHY_ID1`/`PHY_ID2`; these are read-only and writes to them are ignored.
  - All other registers = 0.
- Writing reg0 with bit15 set restores all reset values. reg0 bit15 reads back 0.
- FSM states:
  - IDLE: `pre_cnt` counts consecutive 1 bits and saturates at 32. A 0 bit with `pre_cnt`==32 goes to ST2. A 0 bit with `pre_cnt`<32 clears `pre_cnt`.
  - ST2: a 1 bit goes to OP. A 0 bit aborts to IDLE.
  - OP: collects 2 bits. 10 = read, 01 = write. 00 or 11 aborts to IDLE.
  - PHYA: collects 5 bits, MSB first.
  - REGA: collects 5 bits, MSB first. Then, if the PHY address equals `PHYAD`, goes to TA; otherwise goes to SKIP.
  - TA: 2 bits. On a read, the responder does not drive during the first TA bit. On the tick that samples the first TA bit it asserts `mdio_mdd_oe`=1 and `mdio_mdd_o`=0. On a write, TA bit values are ignored.
  - DATA: 16 bits, MSB first.
    - Read: the tick that samples bit N drives bit N-1; the TA2 tick drives D15.
    - Read: the tick that samples D0 deasserts oe, then the FSM goes to IDLE.
    - Write: data is shifted in. On the D0 tick the register is committed, `wr_valid` pulses, and the FSM goes to IDLE.
  - SKIP: counts 18 ticks with oe=0, then goes to IDLE.
- Aborts and returns to IDLE clear `pre_cnt`. A new frame therefore always needs a fresh preamble.
- Reads of unimplemented behaviour return register contents as stored. All 32 addresses are readable.

## Timing
- Outputs change 3 `sys0_clk` cycles after an MDC rising edge at the pad: 2 sync cycles plus 1 register cycle.
- The MDC high and low phases must each be at least 4 `sys0_clk` cycles. Faster MDC is out of spec and its behaviour is undefined.
- `wr_valid` is high for exactly 1 cycle. `wr_addr` and `wr_data` hold until the next write.
- Reset values: `mdio_mdd_o`=0, `mdio_mdd_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, FSM=IDLE, `pre_cnt`=0.
- Reset asserted mid-frame: oe drops asynchronously, and no commit occurs.
- `busy` rises on the ST2 entry tick and falls on the IDLE entry tick.

## Configuration
- `MDIO_RESP_PRE_SUPPRESS_EN`:
  - Defined: IDLE accepts a 0 bit as start with any `pre_cnt`, including 0, but only after at least one tick has elapsed since the previous frame ended. This is Clause-22 preamble suppression.
  - Undefined: 32 preamble ones are mandatory.

## Test plan
- Write frame: 32 ones, 01, 01, PHYAD=1, REGA=4, TA=10, data 16'hA5C3 -> `wr_valid` pulses once with `wr_addr`=4 and `wr_data`=16'hA5C3. A subsequent read of reg4 returns 16'hA5C3.
- Read of reg2 -> oe is low during TA1. TA2 is driven 0. 16 bits of 16'h0141 are driven MSB-first. oe is low after D0.
- Frame to PHYAD=7 -> oe is never asserted, `wr_valid` never pulses, and the next valid frame is accepted.
- Frame with only 31 preamble ones (macro undefined) -> ignored. With the macro defined, the same frame is accepted.
- OP=11 and bad ST (00) -> abort to IDLE with `busy` low within 1 tick. No drive, no write.
- Write reg0=16'h8000 after reg4 was written -> reg4 reads 0 and reg0 reads 16'h1140. Asserting `sys0_rst` mid-read drops oe within 1 cycle.
